// File: rtl/soda_pkg.sv
// Shared constants and types for the soda vending controller.
// Optional change output is enabled by defining SODA_CHANGE_EN.
package soda_pkg;

    localparam int W = 8;

    // FSM state encoding
    localparam logic [1:0] INIT = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ADD  = 2'd2;
    localparam logic [1:0] DISP = 2'd3;

    // Coin values in cents
    localparam logic [W-1:0] NICKEL  = 8'd5;
    localparam logic [W-1:0] DIME    = 8'd10;
    localparam logic [W-1:0] QUARTER = 8'd25;

    // Datapath controls driven by the FSM
    typedef struct packed {
        logic tot_ld;
        logic tot_clr;
    } dp_ctrl_t;

endpackage

// File: rtl/soda_machine_dp.sv
// Datapath: running-total register, saturating coin adder and cost comparator.
// With SODA_CHANGE_EN defined it also exposes tot - s for the change register.
module soda_machine_dp
    import soda_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  dp_ctrl_t      ctrl,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  s,
`ifdef SODA_CHANGE_EN
    output logic [W-1:0]  tot_minus_s,
`endif
    output logic          tot_lt_s
);

    logic [W-1:0] tot_reg;
    logic [W:0]   sum;
    logic [W-1:0] sat_sum;

    assign sum = {1'b0, tot_reg} + {1'b0, a};

    // Carry out forces every bit high, clamping the total at 255
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_sat
            assign sat_sum[gi] = sum[gi] | sum[W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tot_reg <= '0;
        end else if (ctrl.tot_clr) begin
            tot_reg <= '0;
        end else if (ctrl.tot_ld) begin
            tot_reg <= sat_sum;
        end
    end

    assign tot_lt_s = tot_reg < s;

`ifdef SODA_CHANGE_EN
    assign tot_minus_s = tot_reg - s;
`endif

endmodule

// File: rtl/soda_machine_top.sv
// Coin-accepting soda vending controller: edge-detected coin strobe, FSM and datapath.
// Define SODA_CHANGE_EN to add the registered change output chg.
module soda_machine_top
    import soda_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          c,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  s,
`ifdef SODA_CHANGE_EN
    output logic [W-1:0]  chg,
`endif
    output logic          d
);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       c_q_reg;
    logic       coin;
    logic       vend_ok;
    logic       tot_lt_s;
    dp_ctrl_t   ctrl;

    assign coin    = c & ~c_q_reg;
    // A zero cost disables vending; coins are still accumulated
    assign vend_ok = (s != '0) && !tot_lt_s;

    always_comb begin
        state_next = state_reg;
        ctrl       = '0;
        case (state_reg)
            INIT: begin
                ctrl.tot_clr = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                if (coin) begin
                    state_next = ADD;
                end else if (vend_ok) begin
                    state_next = DISP;
                end
            end
            ADD: begin
                ctrl.tot_ld = 1'b1;
                state_next  = WAIT;
            end
            DISP: begin
                state_next = INIT;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= INIT;
            c_q_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            c_q_reg   <= c;
        end
    end

    assign d = (state_reg == DISP);

`ifdef SODA_CHANGE_EN
    logic [W-1:0] tot_minus_s;
    logic [W-1:0] chg_reg;

    // Capture the overpayment on the WAIT->DISP transition and hold it until the next vend
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chg_reg <= '0;
        end else if (state_reg == WAIT && state_next == DISP) begin
            chg_reg <= tot_minus_s;
        end
    end

    assign chg = chg_reg;
`endif

    soda_machine_dp u_dp (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (ctrl),
        .a           (a),
        .s           (s),
`ifdef SODA_CHANGE_EN
        .tot_minus_s (tot_minus_s),
`endif
        .tot_lt_s    (tot_lt_s)
    );

endmodule

// File: tb/tb_soda_machine_top.sv
// Directed, table-driven bench for soda_machine_top (optionally with SODA_CHANGE_EN).
module tb_soda_machine_top;
    import soda_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         c;
    logic [7:0]   a;
    logic [7:0]   s;
    logic         d;
`ifdef SODA_CHANGE_EN
    logic [7:0]   chg;
`endif

    always #5 clk = ~clk;

    soda_machine_top u_dut (
        .clk (clk),
        .rst (rst),
        .c   (c),
        .a   (a),
        .s   (s),
`ifdef SODA_CHANGE_EN
        .chg (chg),
`endif
        .d   (d)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] s;
        int         exp_tot;
        int         exp_vend;
        int         exp_vend_tot;
        int         exp_chg;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   d_cycles = 0;
    int   tot_at_d = 0;

    // Count every cycle d is high and record the total shown while dispensing
    always @(negedge clk) begin
        if (d === 1'b1) begin
            d_cycles = d_cycles + 1;
            tot_at_d = int'(u_dut.u_dp.tot_reg);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input int va, input int vs, input int t, input int v, input int vt, input int ch);
        vec_t e;
        e.a = 8'(va); e.s = 8'(vs); e.exp_tot = t; e.exp_vend = v; e.exp_vend_tot = vt; e.exp_chg = ch;
        vecs.push_back(e);
    endtask

    // One coin: strobe high for 1 cycle, low for 4 so any vend fully completes
    task automatic apply_vec(input int idx);
        int base;
        base = d_cycles;
        c = 1'b1; a = vecs[idx].a; s = vecs[idx].s;
        @(negedge clk);
        c = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        $display("vec %0d: a=%0d s=%0d tot=%0d d_cycles=%0d", idx, vecs[idx].a, vecs[idx].s,
                 u_dut.u_dp.tot_reg, d_cycles - base);
        check($sformatf("vec%0d_tot", idx), int'(u_dut.u_dp.tot_reg), vecs[idx].exp_tot);
        check($sformatf("vec%0d_vend", idx), d_cycles - base, vecs[idx].exp_vend);
        if (vecs[idx].exp_vend != 0)
            check($sformatf("vec%0d_vend_tot", idx), tot_at_d, vecs[idx].exp_vend_tot);
`ifdef SODA_CHANGE_EN
        check($sformatf("vec%0d_chg", idx), int'(chg), vecs[idx].exp_chg);
`endif
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply_vec(i);
    endtask

    initial begin
        int base;
        // s = 150: four quarters, five dimes (vend), then three nickels
        add_vec(25, 150, 25, 0, 0, 0);   add_vec(25, 150, 50, 0, 0, 0);
        add_vec(25, 150, 75, 0, 0, 0);   add_vec(25, 150, 100, 0, 0, 0);
        add_vec(10, 150, 110, 0, 0, 0);  add_vec(10, 150, 120, 0, 0, 0);
        add_vec(10, 150, 130, 0, 0, 0);  add_vec(10, 150, 140, 0, 0, 0);
        add_vec(10, 150, 0, 1, 150, 0);
        add_vec(5, 150, 5, 0, 0, 0);     add_vec(5, 150, 10, 0, 0, 0);
        add_vec(5, 150, 15, 0, 0, 0);
        // s = 200: six quarters, four dimes, two nickels
        for (int i = 1; i <= 6; i++) add_vec(25, 200, 25 * i, 0, 0, 0);
        for (int i = 1; i <= 4; i++) add_vec(10, 200, 150 + 10 * i, 0, 0, 0);
        add_vec(5, 200, 195, 0, 0, 0);   add_vec(5, 200, 0, 1, 200, 0);
        // s = 30: quarter then dime overpays by 5
        add_vec(25, 30, 25, 0, 0, 0);    add_vec(10, 30, 0, 1, 35, 5);
        // s = 0 after a held quarter: eleven more quarters saturate at 255
        for (int i = 2; i <= 12; i++) add_vec(25, 0, (25 * i > 255) ? 255 : 25 * i, 0, 0, 5);

        rst = 1'b0; c = 1'b0; a = 8'd0; s = 8'd150;
        repeat (2) @(negedge clk);
        #1;
        $display("reset: d=%0d tot=%0d", d, u_dut.u_dp.tot_reg);
        check("reset_d", int'(d), 0);
        check("reset_tot", int'(u_dut.u_dp.tot_reg), 0);
`ifdef SODA_CHANGE_EN
        check("reset_chg", int'(chg), 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            $display("idle %0d: d=%0d", i, d);
            check($sformatf("idle%0d_d", i), int'(d), 0);
        end

        run_range(0, 11);

        // Asynchronous reset mid-cycle must clear the credit immediately
        #2;
        rst = 1'b0;
        #1;
        $display("async reset: d=%0d tot=%0d", d, u_dut.u_dp.tot_reg);
        check("async_rst_tot", int'(u_dut.u_dp.tot_reg), 0);
        check("async_rst_d", int'(d), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;

        run_range(12, 25);

        // Coin strobe held for 10 cycles is credited once
        base = d_cycles;
        c = 1'b1; a = 8'd25; s = 8'd0;
        repeat (10) @(negedge clk);
        c = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        $display("held coin: tot=%0d d_cycles=%0d", u_dut.u_dp.tot_reg, d_cycles - base);
        check("held_tot", int'(u_dut.u_dp.tot_reg), 25);
        check("held_vend", d_cycles - base, 0);
`ifdef SODA_CHANGE_EN
        check("held_chg", int'(chg), 5);
`endif

        run_range(26, 36);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
